// File: rtl/stack_unit_ctrl.sv
// stack_unit_ctrl
//   Sequencing controller for a stack unit. It accepts push, pop and peek
//   requests from a producer and drives the external stack register bank.
//   It keeps the stack pointer and hands pop and peek results to a consumer.
//
//   Handshakes (level transition, both sides):
//     producer : a request is pending while rdy_in != rdy_s. When the request
//                is consumed, ack_out toggles and rdy_s takes the value of
//                rdy_in. op and data_in must stay stable while pending.
//     consumer : rdy_out toggles when data_out holds a new result. The output
//                slot is free again once ack_in == rdy_out.
//
//   Optional feature macro: STACK_UNIT_PEEK_EN
//     defined   : op 2'b10 returns the top word and leaves sp unchanged.
//     undefined : op 2'b10 is rejected in the same way as op 2'b11.
//
//   Ports
//     clock, reset_n        clock; synchronous active-low reset
//     rdy_in, op, data_in   producer request (op: 00 push, 01 pop, 10 peek)
//     ack_out               producer acknowledge (toggles)
//     rdy_out, data_out     result to consumer; ack_in is consumer acknowledge
//     err                   1 if the last consumed request was rejected
//     sp                    number of stored words, 0..DEPTH
//     mem_we/addr/wdata     stack memory write port; mem_rdata reads mem_addr
//     fsm_state             current controller state, for debug
module stack_unit_ctrl #(
  parameter int N          = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rdy_in,
  input  logic [1:0]            op,
  input  logic [N-1:0]          data_in,
  output logic                  ack_out,
  output logic                  rdy_out,
  input  logic                  ack_in,
  output logic [N-1:0]          data_out,
  output logic                  err,
  output logic [DEPTH_LOG2:0]   sp,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [N-1:0]          mem_wdata,
  input  logic [N-1:0]          mem_rdata,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NOTIFY   = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2:0]   SP_FULL  = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   SP_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);

  state_t state;
  logic   rdy_s;

  logic pending, full, empty, slot_free;
  logic is_push, is_pop, is_peek, is_read;
  logic do_push, do_read;
  logic [DEPTH_LOG2-1:0] top_addr;

  assign pending   = rdy_in ^ rdy_s;
  assign full      = (sp == SP_FULL);
  assign empty     = (sp == '0);
  assign slot_free = (ack_in == rdy_out);

  assign is_push = (op == 2'b00);
  assign is_pop  = (op == 2'b01);
`ifdef STACK_UNIT_PEEK_EN
  assign is_peek = (op == 2'b10);
`else
  assign is_peek = 1'b0;
`endif
  assign is_read = is_pop | is_peek;

  // When sp == DEPTH the low bits are 0, and subtracting 1 wraps them
  // to DEPTH-1. That is the correct address of the top word.
  assign top_addr = sp[DEPTH_LOG2-1:0] - ADDR_ONE;

  assign do_push = (state == IDLE) && pending && is_push && !full;
  assign do_read = (state == IDLE) && pending && is_read && !empty;

  assign mem_we    = do_push;
  assign mem_wdata = data_in;
  assign fsm_state = state;

  always_comb begin
    mem_addr = '0;
    if (do_push)
      mem_addr = sp[DEPTH_LOG2-1:0];
    else if (do_read)
      mem_addr = top_addr;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      sp       <= '0;
      rdy_s    <= 1'b0;
      ack_out  <= 1'b0;
      rdy_out  <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            if (do_push) begin
              sp      <= sp + SP_ONE;
              err     <= 1'b0;
              ack_out <= ~ack_out;
              rdy_s   <= rdy_in;
            end else if (is_read && !empty) begin
              // A read is only consumed once the result can be handed over.
              // Otherwise the controller parks and re-evaluates later.
              if (slot_free) begin
                data_out <= mem_rdata;
                if (is_pop)
                  sp <= sp - SP_ONE;
                state <= NOTIFY;
              end else begin
                state <= WAIT_OUT;
              end
            end else begin
              // Push when full, read when empty, reserved op, or disabled peek.
              err     <= 1'b1;
              ack_out <= ~ack_out;
              rdy_s   <= rdy_in;
            end
          end
        end
        NOTIFY: begin
          rdy_out <= ~rdy_out;
          ack_out <= ~ack_out;
          rdy_s   <= rdy_in;
          err     <= 1'b0;
          state   <= IDLE;
        end
        WAIT_OUT: begin
          if (slot_free)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_unit_ctrl.md
Name: stack_unit_ctrl

Overview:
Sequencing controller for the stack unit datapath.
- Accepts push/pop requests from a producer over a level-transition (RDY/ACK toggle) interface.
- Drives the write enable and address of the stack memory, which is an external bank of N-bit registers, and the beta of the N-bit output register.
- Maintains the stack pointer.
- Hands pop results to a consumer over a second level-transition interface.

Parameters:
- N, 32, data width of stack words
- DEPTH_LOG2, 4, log2 of stack depth (DEPTH = 2**DEPTH_LOG2 = 16)

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset_n  input  1  synchronous active-low reset, sampled on posedge clock
- rdy_in  input  1  producer request line; a request is pending when rdy_in != internal rdy_s
- op  input  2  operation code: 2'b00 push, 2'b01 pop, 2'b10 peek, 2'b11 reserved
- data_in  input  N  push operand, valid while a request is pending
- ack_out  output  1  toggles once per consumed request
- rdy_out  output  1  toggles when data_out holds a new result
- ack_in  input  1  consumer acknowledge; the output slot is free when ack_in == rdy_out
- data_out  output  N  output register value (pop/peek result)
- err  output  1  1 if the last consumed request was rejected
- sp  output  DEPTH_LOG2+1  number of stored words, range 0..DEPTH
- mem_we  output  1  stack memory write enable (beta of the addressed register)
- mem_addr  output  DEPTH_LOG2  stack memory address
- mem_wdata  output  N  stack memory write data
- mem_rdata  input  N  combinational read data at mem_addr

Behaviour:
- Clocking and reset:
  - Everything is sampled and updated on posedge clock.
  - Reset (reset_n=0 at posedge) in any state: state=IDLE, sp=0, rdy_s=0, ack_out=0, rdy_out=0, err=0, data_out=0, mem_we=0, mem_addr=0.
  - Stack contents are logically discarded on reset. A request in flight is dropped, not acknowledged.
- Flags: full = (sp==DEPTH); empty = (sp==0).
- mem_wdata = data_in (combinational). mem_we is combinational and asserts only in the IDLE push-accept cycle.
- State IDLE, with pending = rdy_in ^ rdy_s:
  - No pending request: hold all outputs.
  - Push, not full: mem_we=1, mem_addr=sp[DEPTH_LOG2-1:0]; at the edge sp<=sp+1, err<=0, ack_out toggles, rdy_s<=rdy_in. Stay in IDLE. Latency 1 cycle.
  - Pop or peek, not empty, output slot free: mem_addr=sp-1; at the edge data_out<=mem_rdata, sp decremented only for pop. Go to NOTIFY.
  - Pop or peek, not empty, slot busy (ack_in != rdy_out): go to WAIT_OUT. Nothing is consumed.
  - Push and full, pop/peek and empty, or op=2'b11: err<=1, ack_out toggles, rdy_s<=rdy_in, no memory or sp change. Stay in IDLE.
- State NOTIFY (1 cycle): rdy_out toggles, ack_out toggles, rdy_s<=rdy_in, err<=0. Go to IDLE. Pop/peek latency is 2 cycles, request detection to ack.
- State WAIT_OUT: hold until ack_in == rdy_out, then go to IDLE, where the request is re-evaluated.
- Only one request is processed at a time.
- Push after pop reuses the freed address; sp never wraps.
- op and data_in must stay stable while a request is pending. This is a producer obligation and is not checked.
- A new request toggle is seen no earlier than the cycle after ack_out toggles.

Optional Feature:
- Macro: STACK_UNIT_PEEK_EN.
- Defined: op=2'b10 reads the top without changing sp, as described above.
- Undefined: op=2'b10 is treated like 2'b11: rejected with err<=1, ack_out toggles, no sp or data_out change. The op port width is unchanged.

Test Plan:
- Reset, then push 0xA5A5A5A5 (toggle rdy_in) -> mem_we=1 at mem_addr=0 for exactly one cycle; sp=1, ack_out toggles 1 cycle after request, err=0.
- Push 0x11, 0x22, then pop twice, acking each result -> data_out=0x22 then 0x11; rdy_out toggles twice; sp 2->1->0.
- Pop on empty stack -> err=1, ack_out toggles, sp=0, rdy_out unchanged. A following valid push clears err to 0.
- 16 pushes, then a 17th -> sp=16, 17th rejected with err=1, no mem_we. Then pop -> returns the 16th value, sp=15.
- Pop result not acked by consumer, second pop issued -> controller sits in WAIT_OUT, ack_out not toggled. After ack_in toggles, second pop completes 2 cycles after leaving WAIT_OUT.
- Peek with STACK_UNIT_PEEK_EN defined on stack [0x7] -> data_out=0x7, sp stays 1. Without the macro -> err=1, sp=1. reset_n=0 during NOTIFY -> next cycle sp=0, rdy_out=0, ack_out=0.
